mac_vert_column_scheduler: RTL
==============================

// Module: mac_vert_column_scheduler
// PURPOSE
//  Sequences one vertical bit-serial MAC unit through one dot-product job: one weight bit-column per issue, LSB first.
//  Accepts a job over a valid/ready handshake, then consumes DATA_WIDTH column descriptors over a second handshake.
//  Drives the MAC's en / load_accum / column_idx / is_msb / is_pooling and drains its 2-stage pipeline.
//  Flags the accumulated result valid until the consumer accepts it. Sits between the column-descriptor source and the MAC.
// PARAMETERS
//  DATA_WIDTH  8   weight bit-width; number of columns per job.
//  COL_W       $clog2(DATA_WIDTH)  column index width.
//  PIPE_LAT    2   MAC stages from issue to accumulator update (psum reg, accum reg); must be >=2.
// PORTS
//  clk             in   1      clock
//  reset           in   1      synchronous, active-high reset
//  job_valid       in   1      new job offered
//  job_ready       out  1      scheduler can accept a job (state IDLE)
//  job_pooling     in   1      job is a max-pool compare; sampled on job handshake
//  col_valid       in   1      column descriptor (act_sel/hamming/mul fields, wired straight to MAC) valid
//  col_ready       out  1      descriptor consumed this cycle when col_valid && col_ready
//  col_zero        in   1      descriptor's weight column is all-zero (used only with SKIP_ZERO_COL_EN)
//  mac_en          out  1      MAC pipeline advance
//  mac_load_accum  out  1      MAC accumulator loads result_prev instead of feedback
//  mac_column_idx  out  COL_W  shift amount of the column being issued
//  mac_is_msb      out  1      issued column is DATA_WIDTH-1 (two's-complement negate)
//  mac_is_pooling  out  1      job_pooling held for the whole job and result phase
//  res_valid       out  1      MAC result port holds the finished job
//  res_ready       in   1      consumer takes result when res_valid && res_ready
//  busy            out  1      state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, col counter 0, drain counter 0; every output 0 except job_ready=1.
//  FSM: IDLE -job fire-> RUN -last column issued-> DRAIN -PIPE_LAT-1 en cycles-> DONE -res fire-> IDLE.
//  RUN: col_ready=1; issue = col_valid&&col_ready; mac_en=issue; column_idx=counter; is_msb=(counter==DATA_WIDTH-1).
//  Counter increments per issue; no issue (col_valid=0) -> mac_en=0, MAC frozen, nothing advances (stall-safe).
//  load_accum: high on the first mac_en cycle AFTER the job's first issued column (aligned with accum stage),
//   low otherwise; a stall between them delays load_accum with no lost cycle.
//  DRAIN: mac_en=1 for PIPE_LAT-1 cycles; col_ready=0; column_idx/is_msb=0.
//  DONE: mac_en=0, res_valid=1 held until res_ready; res_valid && res_ready -> IDLE next cycle.
//  job_ready only in IDLE; a job offered in the DONE->IDLE handoff cycle waits one cycle (no bypass).
//  Latency, no stalls: job fire at t, columns t+1..t+8, drain t+9, res_valid from t+10.
//  Reset mid-job: abort to IDLE next edge; partial accumulation discarded; no res_valid.
//  job_valid/col_valid ignored in states where the matching ready is 0.
// CONFIGURATION
//  SKIP_ZERO_COL_EN defined: in RUN, col_valid&&col_zero with counter<DATA_WIDTH-1 consumes descriptor
//   (col_ready=1), increments counter, keeps mac_en=0. MSB column is never skipped.
//   load_accum aligns to the first NON-skipped column; all-zero job -> MSB only, result = result_prev.
//  Not defined: col_zero ignored; every column issues; RUN lasts exactly DATA_WIDTH issues.
// STRUCTURE
//  Package bitsim_sched_pkg: sched_state_t enum {IDLE,RUN,DRAIN,DONE}; COL_W; PIPE_LAT default.
//  One sub-module: sched_col_counter (COL_W counter, inc/clear, last-column flag).
//  FSM, load_accum pending flag and drain counter live in the top.
// TESTING
//  Reset: reset=1 2 cycles -> job_ready=1, all other outputs 0; reset mid-RUN at column 3 -> IDLE, no res_valid.
//  Back-to-back columns: job fire, col_valid=1 always -> column_idx 0..7, is_msb only at 7, load_accum once
//   (cycle of column 1), res_valid 2 cycles after column 7; with golden MAC, result == sum(w*a).
//  Stalls: col_valid low 3 cycles after column 0 and 2 after column 5 -> mac_en low exactly then;
//   load_accum lands on column 1's issue; same result as unstalled run.
//  Result backpressure: res_ready low 5 cycles -> res_valid held, job_ready=0; new job accepted cycle after res fire.
//  Pooling: job_pooling=1 -> mac_is_pooling=1 from job fire through res fire, then 0.
//  SKIP_ZERO_COL_EN: col_zero on columns 0,1,4 -> mac_en only for 2,3,5,6,7; load_accum with column 3's issue;
//   all-zero job -> single issue (idx 7), result == result_prev.

Source files
------------

// File: rtl/mac_vert_column_scheduler_pkg.sv
// Shared state encoding and default sizing for the vertical bit-serial MAC column scheduler.
package bitsim_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int COL_W          = $clog2(DATA_WIDTH_DEF);
  localparam int PIPE_LAT_DEF   = 2;

endpackage

// File: rtl/mac_vert_column_scheduler_col_counter.sv
// Column index counter for one job: cleared on job accept, advanced once per consumed descriptor.
module sched_col_counter
  import bitsim_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int COL_W      = $clog2(DATA_WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [COL_W-1:0] o_count,
  output logic             o_last
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(DATA_WIDTH - 1);

  logic [COL_W-1:0] r_count;

  // Wrap explicitly on the last column so non-power-of-two widths stay in range.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      if (r_count == LAST_COL) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == LAST_COL);

endmodule

// File: rtl/mac_vert_column_scheduler.sv
// Sequences a vertical bit-serial MAC through one dot-product job, one weight column per issue, LSB first.
// Optional build macro SKIP_ZERO_COL_EN: consume all-zero non-MSB columns without issuing them.
module mac_vert_column_scheduler
  import bitsim_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int COL_W      = $clog2(DATA_WIDTH),
  parameter int PIPE_LAT   = PIPE_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic             job_pooling,
  input  logic             col_valid,
  output logic             col_ready,
  input  logic             col_zero,
  output logic             mac_en,
  output logic             mac_load_accum,
  output logic [COL_W-1:0] mac_column_idx,
  output logic             mac_is_msb,
  output logic             mac_is_pooling,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  localparam int                 DRN_W      = (PIPE_LAT > 2) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DRN_W-1:0]   DRAIN_LAST = DRN_W'(PIPE_LAT - 2);

  sched_state_t     r_state;
  sched_state_t     w_next;
  logic [COL_W-1:0] w_count;
  logic             w_last;
  logic [DRN_W-1:0] r_drain;
  logic             r_issued;
  logic             r_loaded;
  logic             r_pooling;
  logic             w_job_fire;
  logic             w_col_fire;
  logic             w_skip;
  logic             w_issue;

  assign w_job_fire = job_valid && (r_state == IDLE);
  assign w_col_fire = col_valid && (r_state == RUN);

`ifdef SKIP_ZERO_COL_EN
  assign w_skip = col_zero && !w_last;
`else
  assign w_skip = col_zero & 1'b0;
`endif

  assign w_issue = w_col_fire && !w_skip;

  sched_col_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .COL_W      (COL_W)
  ) u_col_counter (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_job_fire),
    .i_inc   (w_col_fire),
    .o_count (w_count),
    .o_last  (w_last)
  );

  // Next-state and handshake/MAC control decode.
  always_comb begin
    w_next         = r_state;
    job_ready      = 1'b0;
    col_ready      = 1'b0;
    mac_en         = 1'b0;
    mac_column_idx = '0;
    mac_is_msb     = 1'b0;
    res_valid      = 1'b0;
    busy           = 1'b1;
    case (r_state)
      IDLE: begin
        job_ready = 1'b1;
        busy      = 1'b0;
        if (w_job_fire) begin
          w_next = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      RUN: begin
        col_ready      = 1'b1;
        mac_en         = w_issue;
        mac_column_idx = w_count;
        mac_is_msb     = w_last;
        if (w_col_fire && w_last) begin
          w_next = DRAIN;
        end else begin
          w_next = RUN;
        end
      end
      DRAIN: begin
        mac_en = 1'b1;
        if (r_drain == DRAIN_LAST) begin
          w_next = DONE;
        end else begin
          w_next = DRAIN;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_next = IDLE;
        end else begin
          w_next = DONE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // The accumulator stage first sees real data one advance after the first issued column.
  assign mac_load_accum = mac_en && r_issued && !r_loaded;
  assign mac_is_pooling = r_pooling;

  // State, drain count, load-alignment flags and the latched pooling mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_drain   <= '0;
      r_issued  <= 1'b0;
      r_loaded  <= 1'b0;
      r_pooling <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == DRAIN) begin
        r_drain <= r_drain + 1'b1;
      end else begin
        r_drain <= '0;
      end
      if (w_job_fire) begin
        r_issued <= 1'b0;
        r_loaded <= 1'b0;
      end else begin
        r_issued <= r_issued | mac_en;
        r_loaded <= r_loaded | mac_load_accum;
      end
      if (w_job_fire) begin
        r_pooling <= job_pooling;
      end else if (res_valid && res_ready) begin
        r_pooling <= 1'b0;
      end else begin
        r_pooling <= r_pooling;
      end
    end
  end

endmodule
